// File: rtl/cpu31_run_ctrl_pkg.sv
// rtl/cpu31_run_ctrl_pkg.sv - shared encodings for the cpu31 run/halt/step controller
//
// Purpose: host command opcodes, sequencer state encoding and the MIPS
// break instruction fields. It also holds a helper that recognises break.
// Ports: none (package).

package cpu31_run_ctrl_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2
  } run_state_t;

  // Host command opcodes; 6 and 7 behave as NOP
  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_RUN    = 3'd1;
  localparam logic [2:0] OP_HALT   = 3'd2;
  localparam logic [2:0] OP_STEP   = 3'd3;
  localparam logic [2:0] OP_SET_BP = 3'd4;
  localparam logic [2:0] OP_CLR_BP = 3'd5;

  // MIPS "break": SPECIAL opcode with funct 0x0D
  localparam logic [5:0] BREAK_OPCODE = 6'h00;
  localparam logic [5:0] BREAK_FUNCT  = 6'h0D;

  function automatic logic is_break(input logic [31:0] inst);
    return (inst[31:26] == BREAK_OPCODE) && (inst[5:0] == BREAK_FUNCT);
  endfunction

endpackage

// File: rtl/cpu31_run_ctrl_bp_match.sv
// rtl/cpu31_run_ctrl_bp_match.sv - PC breakpoint slot registers and address comparator
//
// Purpose: holds NUM_BP breakpoint address/enable pairs. A single write port
// sets or clears one slot. The module flags when any enabled slot equals the
// current PC. A write becomes visible to match on the following cycle.
// Ports:
//   clk_in   in   1   clock
//   reset    in   1   synchronous active-high reset; disables every slot
//   wr_en    in   1   write strobe for slot wr_idx
//   wr_set   in   1   1: load wr_addr and enable slot, 0: disable slot
//   wr_idx   in   3   slot index; indices >= NUM_BP are dropped
//   wr_addr  in   32  breakpoint address for a set
//   pc       in   32  address of the instruction executing this cycle
//   match    out  1   some enabled slot equals pc

module cpu31_run_ctrl_bp_match #(
  parameter int NUM_BP = 2
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        wr_en,
  input  logic        wr_set,
  input  logic [2:0]  wr_idx,
  input  logic [31:0] wr_addr,
  input  logic [31:0] pc,
  output logic        match
);

  logic [31:0]       bp_addr [NUM_BP];
  logic [NUM_BP-1:0] bp_en;

  // Slot indices beyond NUM_BP never compare equal, so out-of-range writes
  // fall through without a separate range check.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      bp_en <= '0;
      for (int i = 0; i < NUM_BP; i++) begin
        bp_addr[i] <= '0;
      end
    end else if (wr_en) begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (wr_idx == 3'(i)) begin
          bp_en[i] <= wr_set;
          if (wr_set) begin
            bp_addr[i] <= wr_addr;
          end
        end
      end
    end
  end

  always_comb begin
    match = 1'b0;
    for (int i = 0; i < NUM_BP; i++) begin
      if (bp_en[i] && (bp_addr[i] == pc)) begin
        match = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu31_run_ctrl.sv
// rtl/cpu31_run_ctrl.sv - run/halt/single-step sequencer for the single-cycle CPU
//
// Purpose: gates the CPU clock enable from a host command port. The block
// supports PC breakpoints, counted single-step and a retired-instruction
// counter.
// Optional feature: define CPU31_BREAK_HALT_EN to make a MIPS break
// instruction trap like a breakpoint.
// Ports:
//   clk_in     in   1      system clock, shared with the CPU
//   reset      in   1      synchronous active-high reset, shared with the CPU
//   cmd_valid  in   1      host command valid
//   cmd_ready  out  1      always 1: commands are accepted with zero latency
//   cmd_op     in   3      0 NOP, 1 RUN, 2 HALT, 3 STEP, 4 SET_BP, 5 CLR_BP
//   cmd_idx    in   3      breakpoint slot for SET_BP/CLR_BP
//   cmd_arg    in   32     SET_BP address / STEP count in [STEP_W-1:0]
//   pc         in   32     address of the instruction executing this cycle
//   inst       in   32     instruction at pc
//   cpu_en     out  1      CPU retires one instruction on an edge with cpu_en=1
//   halted     out  1      sequencer is halted
//   bp_hit     out  1      one-cycle pulse after a halt caused by a trap
//   retired    out  CNT_W  number of cpu_en cycles, wrapping

module cpu31_run_ctrl
  import cpu31_run_ctrl_pkg::*;
#(
  parameter int NUM_BP       = 2,
  parameter int STEP_W       = 16,
  parameter int CNT_W        = 32,
  parameter bit RUN_ON_RESET = 1'b1
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [2:0]       cmd_idx,
  input  logic [31:0]      cmd_arg,
  input  logic [31:0]      pc,
  input  logic [31:0]      inst,
  output logic             cpu_en,
  output logic             halted,
  output logic             bp_hit,
  output logic [CNT_W-1:0] retired
);

  run_state_t        state_q, state_d;
  logic [STEP_W-1:0] step_left_q;
  logic [STEP_W-1:0] step_count;
  logic              skip_q;
  logic [CNT_W-1:0]  retired_q;
  logic              bp_hit_q;

  logic              accept;
  logic              match;
  logic              brk;
  logic              trap;
  logic              exhaust;
  logic              enter;
  logic              load_step;
  logic              bp_wr_en;
  logic              bp_wr_set;

  assign cmd_ready = 1'b1;
  assign accept    = cmd_valid;

  assign bp_wr_en  = accept && ((cmd_op == OP_SET_BP) || (cmd_op == OP_CLR_BP));
  assign bp_wr_set = (cmd_op == OP_SET_BP);

  cpu31_run_ctrl_bp_match #(
    .NUM_BP (NUM_BP)
  ) u_bp_match (
    .clk_in  (clk_in),
    .reset   (reset),
    .wr_en   (bp_wr_en),
    .wr_set  (bp_wr_set),
    .wr_idx  (cmd_idx),
    .wr_addr (cmd_arg),
    .pc      (pc),
    .match   (match)
  );

`ifdef CPU31_BREAK_HALT_EN
  assign brk = is_break(inst);
`else
  logic unused_inst;
  assign brk         = 1'b0;
  assign unused_inst = ^inst;
`endif

  // A zero step count still executes one instruction.
  assign step_count = (cmd_arg[STEP_W-1:0] == '0) ? STEP_W'(1) : cmd_arg[STEP_W-1:0];

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= RUN_ON_RESET ? ST_RUN : ST_HALTED;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  // skip masks the trap for the first instruction after a resume. The CPU can
  // then step off the breakpoint it stopped on.
  always_comb begin
    halted = (state_q == ST_HALTED);
    trap   = !halted && (match || brk) && !skip_q;
    cpu_en = !halted && !trap;
  end

  assign exhaust = (state_q == ST_STEP) && cpu_en && (step_left_q == STEP_W'(1));

  // ---------------------------------------------------------------- next state
  // A trap or an exhausted step count halts the CPU. An accepted RUN, HALT or
  // STEP command then overrides that outcome. RUN arriving on a trap cycle
  // counts as a resume, so skip is rearmed even though the state stays RUN.
  always_comb begin
    state_d   = state_q;
    enter     = 1'b0;
    load_step = 1'b0;
    if (trap || exhaust) begin
      state_d = ST_HALTED;
    end
    if (accept) begin
      case (cmd_op)
        OP_NOP: ;
        OP_RUN: begin
          state_d = ST_RUN;
          enter   = (state_q != ST_RUN) || trap;
        end
        OP_HALT: begin
          state_d = ST_HALTED;
        end
        OP_STEP: begin
          if (state_q == ST_HALTED) begin
            state_d   = ST_STEP;
            enter     = 1'b1;
            load_step = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- datapath regs
  always_ff @(posedge clk_in) begin
    if (reset) begin
      step_left_q <= '0;
      skip_q      <= 1'b1;
      retired_q   <= '0;
      bp_hit_q    <= 1'b0;
    end else begin
      bp_hit_q  <= trap && (state_d == ST_HALTED);
      retired_q <= retired_q + {{(CNT_W-1){1'b0}}, cpu_en};
      if (enter) begin
        skip_q <= 1'b1;
      end else if (cpu_en) begin
        skip_q <= 1'b0;
      end
      if (load_step) begin
        step_left_q <= step_count;
      end else if ((state_q == ST_STEP) && cpu_en) begin
        step_left_q <= step_left_q - STEP_W'(1);
      end
    end
  end

  assign bp_hit  = bp_hit_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_cpu31_run_ctrl.sv
// tb/tb_cpu31_run_ctrl.sv - directed and random bench for cpu31_run_ctrl against a reference model

module tb_cpu31_run_ctrl;

  localparam int          NUM_BP    = 2;
  localparam int          STEP_W    = 16;
  localparam int          CNT_W     = 32;
  localparam logic [31:0] LOOP_BASE = 32'h00400000;
  localparam logic [31:0] LOOP_LAST = 32'h00400010;

  logic             clk_in = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [2:0]       cmd_idx;
  logic [31:0]      cmd_arg;
  logic [31:0]      pc;
  logic [31:0]      inst;
  logic             cpu_en;
  logic             halted;
  logic             bp_hit;
  logic [CNT_W-1:0] retired;

  cpu31_run_ctrl #(
    .NUM_BP       (NUM_BP),
    .STEP_W       (STEP_W),
    .CNT_W        (CNT_W),
    .RUN_ON_RESET (1'b1)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_idx   (cmd_idx),
    .cmd_arg   (cmd_arg),
    .pc        (pc),
    .inst      (inst),
    .cpu_en    (cpu_en),
    .halted    (halted),
    .bp_hit    (bp_hit),
    .retired   (retired)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: mode 0 halted, 1 running, 2 stepping
  int          m_mode;
  logic        m_bp_on [8];
  logic [31:0] m_bp_at [8];
  int          m_steps;
  logic        m_skip;
  logic [31:0] m_retired;
  logic        m_hit;
  logic [31:0] brk_pc;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bench CPU: five-instruction loop, optional break instruction at brk_pc
  task automatic fetch();
    logic [31:0] r;
    r = $urandom();
    inst = (pc == brk_pc) ? 32'h0000000D : {6'h23, r[25:0]};
  endtask

  function automatic logic m_trap();
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_BP; i++) begin
      if (m_bp_on[i] && (m_bp_at[i] == pc)) hit = 1'b1;
    end
`ifdef CPU31_BREAK_HALT_EN
    if ((inst[31:26] == 6'h00) && (inst[5:0] == 6'h0D)) hit = 1'b1;
`endif
    return (m_mode != 0) && hit && !m_skip;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk_in);
    #1;
    reset = 1'b0;
    m_mode = 1;
    for (int i = 0; i < 8; i++) begin
      m_bp_on[i] = 1'b0;
      m_bp_at[i] = '0;
    end
    m_steps   = 0;
    m_skip    = 1'b1;
    m_retired = '0;
    m_hit     = 1'b0;
    pc        = LOOP_BASE;
    fetch();
  endtask

  // One clock: drive a command, compare outputs against the model, advance.
  task automatic cyc(input logic v, input logic [2:0] op, input logic [2:0] idx, input logic [31:0] arg);
    logic tr, en, enter, hn;
    int   nmode;
    cmd_valid = v;
    cmd_op    = op;
    cmd_idx   = idx;
    cmd_arg   = arg;
    #1;
    tr = m_trap();
    en = (m_mode != 0) && !tr;
    check("cpu_en", cpu_en, en);
    check("halted", halted, m_mode == 0);
    check("bp_hit", bp_hit, m_hit);
    check("retired", retired, m_retired);

    nmode = m_mode;
    enter = 1'b0;
    if (tr) nmode = 0;
    else if ((m_mode == 2) && en && (m_steps == 1)) nmode = 0;
    if (v) begin
      case (op)
        3'd1: begin nmode = 1; enter = (m_mode != 1) || tr; end
        3'd2: nmode = 0;
        3'd3: if (m_mode == 0) begin nmode = 2; enter = 1'b1; end
        default: ;
      endcase
    end
    hn = tr && (nmode == 0);

    @(posedge clk_in);
    #1;
    m_retired = m_retired + {31'd0, en};
    if ((m_mode == 2) && en) m_steps = m_steps - 1;
    if (v && (op == 3'd3) && (m_mode == 0)) m_steps = (arg[15:0] == 16'd0) ? 1 : int'(arg[15:0]);
    if (enter) m_skip = 1'b1;
    else if (en) m_skip = 1'b0;
    if (v && ((op == 3'd4) || (op == 3'd5)) && (int'(idx) < NUM_BP)) begin
      m_bp_on[idx] = (op == 3'd4);
      if (op == 3'd4) m_bp_at[idx] = arg;
    end
    m_mode = nmode;
    m_hit  = hn;
    if (en) pc = (pc == LOOP_LAST) ? LOOP_BASE : pc + 32'd4;
    fetch();
  endtask

  task automatic nops(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 3'd0, 3'd0, 32'd0);
  endtask

  // Idle until the model predicts a trap on the current cycle (bounded).
  task automatic wait_trap(input string tag);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (m_trap()) begin
        found = 1'b1;
        break;
      end
      cyc(1'b0, 3'd0, 3'd0, 32'd0);
    end
    check(tag, found, 1'b1);
  endtask

  initial begin
    logic [31:0] nxt, r;
    int          sel;
    pc        = LOOP_BASE;
    brk_pc    = 32'hFFFFFFFF;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_idx   = '0;
    cmd_arg   = '0;
    reset     = 1'b1;
    fetch();
    @(posedge clk_in);
    do_reset();

    // Reset state and free running
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_retired", retired, 32'd0);
    nops(10);
    check("run10_retired", retired, 32'd10);

    // Breakpoint while running, resume, trap on next loop pass
    do_reset();
    cyc(1'b1, 3'd4, 3'd0, 32'h00400008);
    wait_trap("t2_trap1");
    nops(3);
    cyc(1'b1, 3'd1, 3'd0, 32'd0);
    wait_trap("t2_trap2");
    nops(3);

    // Counted steps, then a zero count
    cyc(1'b1, 3'd5, 3'd0, 32'd0);
    cyc(1'b1, 3'd3, 3'd0, 32'h00000003);
    nops(6);
    cyc(1'b1, 3'd3, 3'd0, 32'hABCD0000);
    nops(4);

    // Step cut short by a breakpoint on the second instruction
    nxt = (pc == LOOP_LAST) ? LOOP_BASE : pc + 32'd4;
    cyc(1'b1, 3'd4, 3'd1, nxt);
    cyc(1'b1, 3'd3, 3'd0, 32'd5);
    nops(4);

    // Trap coinciding with HALT, then with RUN
    cyc(1'b1, 3'd1, 3'd0, 32'd0);
    wait_trap("t5_trap_halt");
    cyc(1'b1, 3'd2, 3'd0, 32'd0);
    nops(3);
    cyc(1'b1, 3'd1, 3'd0, 32'd0);
    wait_trap("t5_trap_run");
    cyc(1'b1, 3'd1, 3'd0, 32'd0);
    nops(3);

    // Break instruction, then reset in the middle of a step sequence
    cyc(1'b1, 3'd5, 3'd0, 32'd0);
    cyc(1'b1, 3'd5, 3'd1, 32'd0);
    brk_pc = 32'h0040000C;
    fetch();
    cyc(1'b1, 3'd1, 3'd0, 32'd0);
    nops(12);
    brk_pc = 32'hFFFFFFFF;
    fetch();
    cyc(1'b1, 3'd2, 3'd0, 32'd0);
    cyc(1'b1, 3'd4, 3'd0, 32'h00400004);
    cyc(1'b1, 3'd3, 3'd0, 32'd100);
    nops(2);
    do_reset();
    check("t6_reset_retired", retired, 32'd0);
    check("t6_reset_halted", halted, 1'b0);
    nops(12);

    // Random commands against the model
    for (int n = 0; n < 600; n++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 1) begin
        do_reset();
      end else if (sel < 3) begin
        brk_pc = LOOP_BASE + 32'd4 * $urandom_range(0, 4);
        fetch();
        cyc(1'b0, 3'd0, 3'd0, 32'd0);
      end else if (sel < 55) begin
        cyc(1'b0, 3'($urandom_range(0, 7)), 3'd0, $urandom());
      end else begin
        r = $urandom();
        case (r[2:0])
          3'd3:    cyc(1'b1, 3'd3, 3'd0, ($urandom() & 32'hFFFF0000) | $urandom_range(0, 4));
          3'd4:    cyc(1'b1, 3'd4, r[5:3], LOOP_BASE + 32'd4 * $urandom_range(0, 4));
          default: cyc(1'b1, r[2:0], r[5:3], $urandom());
        endcase
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
